// File: rtl/arcade_ctl_pkg.sv
// Shared types and helpers for the arcade control stroke sequencer.
package arcade_ctl_pkg;

  typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_HOLD, ST_GAP} seq_state_t;

  localparam int FN_COIN   = 0;
  localparam int FN_START1 = 1;
  localparam int FN_START2 = 2;

  typedef logic [2:0] fn_vec_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Fixed priority COIN > START1 > START2, returned one-hot.
  function automatic fn_vec_t prio_onehot(input fn_vec_t p);
    fn_vec_t g;
    g = '0;
    if (p[FN_COIN])        g[FN_COIN]   = 1'b1;
    else if (p[FN_START1]) g[FN_START1] = 1'b1;
    else if (p[FN_START2]) g[FN_START2] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector; history resets high so a level already present at
// reset release is not mistaken for a new request.
module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic pulse_o
);

  logic hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 1'b1;
    else        hist_q <= d_i;
  end

  assign pulse_o = d_i & ~hist_q;

endmodule

// File: rtl/arcade_control_sequencer.sv
// Serialises coin/start requests into fixed-length strokes separated by a
// minimum gap, and stretches OSD reset requests into a timed game reset.
module arcade_control_sequencer
  import arcade_ctl_pkg::*;
#(
  parameter int HOLD_CYCLES = 600000,
  parameter int GAP_CYCLES  = 600000,
  parameter int RST_CYCLES  = 65536,
  parameter int CW          = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, RST_CYCLES)) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic coin_osd,
  input  logic coin_joy,
  input  logic start1_osd,
  input  logic start1_joy,
  input  logic start2_osd,
  input  logic start2_joy,
  input  logic reset_osd,
  output logic coin,
  output logic start1,
  output logic start2,
  output logic game_rst_n,
  output logic busy
);

  localparam int NREQ = 7;

  logic [NREQ-1:0] req_raw;
  logic [NREQ-1:0] req_edge;
  fn_vec_t         fn_edge;
  logic            rst_req;

  seq_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_dec;
  logic            cnt_zero;
  fn_vec_t         pend_q, pend_d;
  fn_vec_t         grant_q, grant_d, grant_pick;
  fn_vec_t         stroke_q;
  logic            game_rst_n_q;
  logic            busy_q;

  assign req_raw = {reset_osd, start2_joy, start2_osd, start1_joy, start1_osd, coin_joy, coin_osd};

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_edge
    edge_pulse u_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_i     (req_raw[gi]),
      .pulse_o (req_edge[gi])
    );
  end

  assign fn_edge[FN_COIN]   = req_edge[0] | req_edge[1];
  assign fn_edge[FN_START1] = req_edge[2] | req_edge[3];
  assign fn_edge[FN_START2] = req_edge[4] | req_edge[5];
  assign rst_req            = req_edge[6];

  assign cnt_zero   = (cnt_q == '0);
  assign cnt_dec    = cnt_q - CW'(1);
  assign grant_pick = prio_onehot(pend_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    grant_d = grant_q;
    case (state_q)
      ST_RESET: begin
        if (cnt_zero) state_d = ST_IDLE;
        else          cnt_d   = cnt_dec;
      end
      ST_IDLE: begin
        pend_d = pend_q | fn_edge;
        if (pend_q != '0) begin
          state_d = ST_HOLD;
          grant_d = grant_pick;
          cnt_d   = CW'(HOLD_CYCLES - 1);
          // A fresh edge for the granted function in this cycle re-queues it.
          pend_d  = (pend_q & ~grant_pick) | fn_edge;
        end
      end
      ST_HOLD: begin
        pend_d = pend_q | fn_edge;
        if (cnt_zero) begin
          state_d = ST_GAP;
          cnt_d   = CW'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_GAP: begin
        pend_d = pend_q | fn_edge;
        if (cnt_zero) state_d = ST_IDLE;
        else          cnt_d   = cnt_dec;
      end
      default: state_d = ST_RESET;
    endcase
    // Reset overrides everything, including requests arriving in the same cycle.
    if (state_q != ST_RESET && rst_req) begin
      state_d = ST_RESET;
      cnt_d   = CW'(RST_CYCLES - 1);
      pend_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      cnt_q        <= CW'(RST_CYCLES - 1);
      pend_q       <= '0;
      grant_q      <= '0;
      stroke_q     <= '0;
      game_rst_n_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      grant_q      <= grant_d;
      stroke_q     <= (state_d == ST_HOLD) ? grant_d : '0;
      game_rst_n_q <= (state_d != ST_RESET);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign coin       = stroke_q[FN_COIN];
  assign start1     = stroke_q[FN_START1];
  assign start2     = stroke_q[FN_START2];
  assign game_rst_n = game_rst_n_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_arcade_control_sequencer.sv
// Scoreboard bench: stimulus pushes expected stroke/reset spans, a monitor
// reconstructs spans from the outputs and checks them in order.
module tb_arcade_control_sequencer;

  localparam int K_COIN = 0;
  localparam int K_S1   = 1;
  localparam int K_S2   = 2;
  localparam int K_RST  = 3;

  typedef struct {
    int kind;
    int start;
    int stop;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  logic coin_osd, coin_joy, start1_osd, start1_joy, start2_osd, start2_joy, reset_osd;
  logic coin, start1, start2, game_rst_n, busy;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  txn_t exp_q[$];

  arcade_control_sequencer #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (3),
    .RST_CYCLES  (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin_osd   (coin_osd),
    .coin_joy   (coin_joy),
    .start1_osd (start1_osd),
    .start1_joy (start1_joy),
    .start2_osd (start2_osd),
    .start2_joy (start2_joy),
    .reset_osd  (reset_osd),
    .coin       (coin),
    .start1     (start1),
    .start2     (start2),
    .game_rst_n (game_rst_n),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_COIN:  return "coin";
      K_S1:    return "start1";
      K_S2:    return "start2";
      default: return "game_rst";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int t0, input int t1);
    txn_t e;
    e.kind  = kind;
    e.start = t0;
    e.stop  = t1;
    exp_q.push_back(e);
  endtask

  task automatic complete(input int kind, input int t0, input int t1);
    txn_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: span %0d..%0d, required no activity", kname(kind), t0, t1);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.start != t0 || e.stop != t1) begin
        n_fail++;
        $display("FAIL txn_%s: got %s %0d..%0d, required %s %0d..%0d",
                 kname(e.kind), kname(kind), t0, t1, kname(e.kind), e.start, e.stop);
      end else begin
        $display("txn ok: %s active cycles %0d..%0d", kname(kind), t0, t1 - 1);
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  logic [2:0] s_prev = 3'b000;
  logic [2:0] s_now;
  logic       grst_prev = 1'b0;
  int         s_start[3];
  int         grst_start = 0;

  always @(posedge clk) begin
    #1;
    s_now = {start2, start1, coin};
    if (!rst_n) grst_start = cyc;
    n_checks++;
    if ($countones(s_now) > 1) begin
      n_fail++;
      $display("FAIL onehot: strokes=%b at cycle %0d, required at most one high", s_now, cyc);
    end
    for (int i = 0; i < 3; i++) begin
      if (s_now[i] && !s_prev[i]) s_start[i] = cyc;
      if (!s_now[i] && s_prev[i]) complete(i, s_start[i], cyc);
    end
    if (!game_rst_n && grst_prev) grst_start = cyc;
    if (game_rst_n && !grst_prev) begin
      complete(K_RST, grst_start, cyc);
      chk("busy_fall_with_game_rst", int'(busy), 0);
    end
    s_prev    = s_now;
    grst_prev = game_rst_n;
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    coin_osd = 1'b1;  // held high across reset release: must never fire
    coin_joy = 1'b0; start1_osd = 1'b0; start1_joy = 1'b0;
    start2_osd = 1'b0; start2_joy = 1'b0; reset_osd = 1'b0;
    #1 rst_n = 1'b0;
    step(3);
    chk("reset_coin",       int'(coin),       0);
    chk("reset_start1",     int'(start1),     0);
    chk("reset_start2",     int'(start2),     0);
    chk("reset_game_rst_n", int'(game_rst_n), 0);
    chk("reset_busy",       int'(busy),       1);

    // Power-up: game reset low for 5 cycles after release.
    n = cyc;
    rst_n = 1'b1;
    push(K_RST, n, n + 5);
    step(2);
    coin_osd = 1'b0;
    step(8);
    chk("idle_busy", int'(busy), 0);

    // Single coin stroke from a joystick pulse.
    n = cyc;
    coin_joy = 1'b1;
    push(K_COIN, n + 2, n + 6);
    step(1);
    coin_joy = 1'b0;
    step(12);

    // Simultaneous coin and start2: coin first, start2 after gap + idle.
    n = cyc;
    coin_osd = 1'b1;
    start2_osd = 1'b1;
    push(K_COIN, n + 2, n + 6);
    push(K_S2, n + 10, n + 14);
    step(1);
    coin_osd = 1'b0;
    start2_osd = 1'b0;
    step(20);

    // Queue depth: repeated start1 edges while start1 is active collapse to one.
    n = cyc;
    start1_joy = 1'b1;
    push(K_S1, n + 2, n + 6);
    push(K_S1, n + 10, n + 14);
    for (int i = 0; i < 3; i++) begin
      step(1);
      start1_joy = 1'b0;
      step(1);
      start1_joy = 1'b1;
    end
    step(1);
    start1_joy = 1'b0;
    step(20);

    // Reset in the 2nd HOLD cycle of coin with start1 pending; start2 during RESET ignored.
    n = cyc;
    coin_joy = 1'b1;
    start1_osd = 1'b1;
    push(K_COIN, n + 2, n + 4);
    push(K_RST, n + 4, n + 9);
    step(1);
    coin_joy = 1'b0;
    start1_osd = 1'b0;
    step(2);
    reset_osd = 1'b1;
    step(1);
    reset_osd = 1'b0;
    step(1);
    start2_osd = 1'b1;
    step(1);
    start2_osd = 1'b0;
    step(20);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_busy", int'(busy), 0);
    chk("final_game_rst_n", int'(game_rst_n), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
